// File: rtl/tff_bank_counter.sv
// -----------------------------------------------------------------------------
// tff_bank_counter
//
// A WIDTH-bit register made of T flip-flop cells. Each cell inverts when its
// toggle enable is high at the rising clock edge. The toggle enables come from
// one of three places:
//   - the external per-bit toggle requests (toggle mode),
//   - the ripple "all lower bits are 1" chain (count up), or
//   - the ripple "all lower bits are 0" chain (count down).
// Counting is done only through these per-bit toggle enables; there is no
// adder. A synchronous parallel load overrides every mode.
//
// Build option:
//   TFF_BANK_COUNTER_SAT_EN - when defined, the up count holds at all-ones and
//                             the down count holds at zero instead of wrapping.
//                             When undefined, both counts wrap.
//
// Parameters:
//   WIDTH   - number of T-FF cells, 1..32
//   RST_VAL - value of q after reset (only the low WIDTH bits are used)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-low
//   en    in   update enable for the toggle and count modes
//   mode  in   00 hold, 01 per-bit toggle, 10 count up, 11 count down
//   t     in   per-bit toggle requests, used only in toggle mode
//   load  in   synchronous parallel load, wins over en/mode
//   d     in   load data
//   q     out  registered state
//   qbar  out  bitwise complement of q (combinational)
//   tc    out  terminal count (combinational): counting and at the wrap point
// -----------------------------------------------------------------------------
module tff_bank_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] tog_up;
    logic [WIDTH-1:0] tog_dn;
    logic [WIDTH-1:0] tog;
    logic             up_run;
    logic             dn_run;
    logic             all_ones;
    logic             all_zero;

    assign all_ones = &q_q;
    assign all_zero = ~|q_q;

    // Ripple toggle chains: bit i toggles when every lower bit is 1 (up) or
    // every lower bit is 0 (down). Bit 0 always toggles.
    always_comb begin
        up_run = 1'b1;
        dn_run = 1'b1;
        tog_up = '0;
        tog_dn = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tog_up[i] = up_run;
            tog_dn[i] = dn_run;
            up_run    = up_run & q_q[i];
            dn_run    = dn_run & ~q_q[i];
        end
    end

    // Select the toggle enables for this edge.
    always_comb begin
        tog = '0;
        case (mode)
            MODE_TOGGLE: tog = t;
            MODE_UP:     tog = tog_up;
            MODE_DOWN:   tog = tog_dn;
            default:     tog = '0;
        endcase
`ifdef TFF_BANK_COUNTER_SAT_EN
        // At the end stop, suppress every toggle so the count sticks.
        if ((mode == MODE_UP) && all_ones) begin
            tog = '0;
        end
        if ((mode == MODE_DOWN) && all_zero) begin
            tog = '0;
        end
`endif
        if (!en) begin
            tog = '0;
        end
    end

    // Load overrides toggling; reset overrides both in the register below.
    always_comb begin
        q_d = q_q ^ tog;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RST_Q;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    // tc looks at the current q, so with a simultaneous load it still reports
    // the pre-load state.
    assign tc   = en & (((mode == MODE_UP) & all_ones) | ((mode == MODE_DOWN) & all_zero));

    // An unknown mode while enabled leaves the next state undefined.
    assert property (@(posedge clk) disable iff (!rst) (en === 1'b1) |-> !$isunknown(mode))
        else $error("tff_bank_counter: mode is unknown while en is high");

endmodule

// File: tb/tb_tff_bank_counter.sv
// -----------------------------------------------------------------------------
// Testbench for tff_bank_counter.
// Instance A: WIDTH=4, RST_VAL=5. Instance B: WIDTH=8, RST_VAL=0.
// A behavioural model computes the next q for every driven cycle and pushes it
// onto a queue; after the clock edge the entry is popped and compared with q.
// -----------------------------------------------------------------------------
module tb_tff_bank_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       rst_a = 1'b0, en_a = 1'b0, load_a = 1'b0;
    logic [1:0] mode_a = 2'b00;
    logic [3:0] t_a = 4'h0, d_a = 4'h0;
    logic [3:0] q_a, qbar_a;
    logic       tc_a;

    // Instance B signals
    logic       rst_b = 1'b0, en_b = 1'b0, load_b = 1'b0;
    logic [1:0] mode_b = 2'b00;
    logic [7:0] t_b = 8'h00, d_b = 8'h00;
    logic [7:0] q_b, qbar_b;
    logic       tc_b;

    tff_bank_counter #(.WIDTH(4), .RST_VAL(32'h5)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .t(t_a),
        .load(load_a), .d(d_a), .q(q_a), .qbar(qbar_a), .tc(tc_a)
    );

    tff_bank_counter #(.WIDTH(8), .RST_VAL(32'h0)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .t(t_b),
        .load(load_b), .d(d_b), .q(q_b), .qbar(qbar_b), .tc(tc_b)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb_q[$];
    logic [7:0] model_a;   // model state, valid once reset has been applied
    logic [7:0] model_b;
    bit         known_a = 1'b0;
    bit         known_b = 1'b0;
    int         tc_hits = 0;

`ifdef TFF_BANK_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] mask, input logic [7:0] cur,
                                              input logic r, input logic l, input logic e,
                                              input logic [1:0] m, input logic [7:0] tt,
                                              input logic [7:0] dd, input logic [7:0] rv);
        logic [7:0] nxt;
        nxt = cur;
        if (!r)      nxt = rv;
        else if (l)  nxt = dd;
        else if (e) begin
            case (m)
                2'b01: nxt = cur ^ tt;
                2'b10: nxt = (SAT && cur == mask) ? cur : cur + 8'd1;
                2'b11: nxt = (SAT && cur == 8'd0) ? cur : cur - 8'd1;
                default: nxt = cur;
            endcase
        end
        return nxt & mask;
    endfunction

    function automatic logic model_tc(input logic [7:0] mask, input logic [7:0] cur,
                                      input logic e, input logic [1:0] m);
        return e && (((m == 2'b10) && (cur == mask)) || ((m == 2'b11) && (cur == 8'd0)));
    endfunction

    // One cycle on instance A: drive inputs, check the combinational outputs
    // and the unchanged q before the edge, then compare the popped expectation.
    task automatic step_a(input string tag, input logic r, input logic l, input logic e,
                          input logic [1:0] m, input logic [3:0] tt, input logic [3:0] dd);
        logic [7:0] exp;
        rst_a = r; load_a = l; en_a = e; mode_a = m; t_a = tt; d_a = dd;
        #1;
        if (known_a) begin
            check_eq({tag, "_qpre"}, {4'h0, q_a}, model_a);
            check_eq({tag, "_tc"}, {7'h0, tc_a}, {7'h0, model_tc(8'h0F, model_a, e, m)});
        end
        sb_q.push_back(model_next(8'h0F, model_a, r, l, e, m, {4'h0, tt}, {4'h0, dd}, 8'h05));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sbempty"}, 8'h01, 8'h00);
        end else begin
            exp = sb_q.pop_front();
            if (!r) known_a = 1'b1;
            if (known_a) begin
                check_eq({tag, "_q"}, {4'h0, q_a}, exp);
                check_eq({tag, "_qbar"}, {4'h0, qbar_a}, {4'h0, ~exp[3:0]});
            end
            model_a = exp;
        end
    endtask

    task automatic step_b(input string tag, input logic r, input logic l, input logic e,
                          input logic [1:0] m);
        logic [7:0] exp;
        rst_b = r; load_b = l; en_b = e; mode_b = m; t_b = 8'h00; d_b = 8'h00;
        #1;
        if (known_b) begin
            if (tc_b === 1'b1) tc_hits++;
            check_eq({tag, "_tc"}, {7'h0, tc_b}, {7'h0, model_tc(8'hFF, model_b, e, m)});
        end
        sb_q.push_back(model_next(8'hFF, model_b, r, l, e, m, 8'h00, 8'h00, 8'h00));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sbempty"}, 8'h01, 8'h00);
        end else begin
            exp = sb_q.pop_front();
            if (!r) known_b = 1'b1;
            if (known_b) begin
                check_eq({tag, "_q"}, q_b, exp);
                check_eq({tag, "_qbar"}, qbar_b, ~exp);
            end
            model_b = exp;
        end
    endtask

    initial begin
        model_a = 8'h00;
        model_b = 8'h00;
        @(posedge clk);
        #1;

        // Reset held across two edges, load asserted with it.
        step_a("rst0", 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'hA);
        step_a("rst1", 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'hA);
        // Load 3, then drive rst low mid-cycle: q must not move before the edge.
        step_a("ld3", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h3);
        step_a("rstmid", 1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);

        // Toggle mode.
        step_a("ld0", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step_a("tog", 1'b1, 1'b0, 1'b1, 2'b01, 4'hA, 4'h0);
        step_a("tog_hold", 1'b1, 1'b0, 1'b0, 2'b01, 4'hA, 4'h0);
        step_a("tog_b", 1'b1, 1'b0, 1'b1, 2'b01, 4'h5, 4'h0);
        step_a("hold00", 1'b1, 1'b0, 1'b1, 2'b00, 4'hF, 4'h0);

        // Up wrap from E.
        step_a("ldE", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'hE);
        for (int i = 0; i < 3; i++) step_a("up", 1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        step_a("up_off", 1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 4'h0);

        // Down wrap from 1.
        step_a("ld1", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h1);
        for (int i = 0; i < 3; i++) step_a("dn", 1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        step_a("ld8", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h8);
        step_a("dn8", 1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);

        // Priority: load over count, reset over load.
        step_a("ld7", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h7);
        step_a("prio_ld", 1'b1, 1'b1, 1'b1, 2'b10, 4'h0, 4'h3);
        step_a("ld7b", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h7);
        step_a("prio_rst", 1'b0, 1'b1, 1'b1, 2'b10, 4'h0, 4'h3);
        // Load at all-ones in up mode: tc reports the pre-load q.
        step_a("ldF", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'hF);
        step_a("ld_tc", 1'b1, 1'b1, 1'b1, 2'b10, 4'h0, 4'h3);
        // Mode change takes effect immediately.
        step_a("mc_up", 1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        step_a("mc_dn", 1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        step_a("mc_dn2", 1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);

        // Full-range count on the 8-bit instance.
        step_b("b_rst", 1'b0, 1'b0, 1'b0, 2'b00);
        tc_hits = 0;
        for (int i = 0; i < 256; i++) step_b("b_up", 1'b1, 1'b0, 1'b1, 2'b10);
        check_eq("b_tc_once", tc_hits[7:0], 8'd1);
        check_eq("b_final", q_b, SAT ? 8'hFF : 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
